oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014: CPU address whose write launches a DMA.
REQ-002 Port clk, input, 1: single clock (CPU-cycle rate); all flops on its rising edge.
REQ-003 Port nres, input, 1: reset, asynchronous assert, active-low.
REQ-004 Port cpu_addr, input, 16: CPU bus address.
REQ-005 Port cpu_data_out, input, 8: CPU write data.
REQ-006 Port cpu_we, input, 1: CPU write strobe, one cycle per write.
REQ-007 Port mem_data_in, input, 8: CPU-bus read data, valid the cycle after dma_rd.
REQ-008 Port oam_base, input, 8: current PPU OAMADDR; DMA target offset.
REQ-009 Port oam_dma, output, 1: DMA busy; top level drives CPU rdy = ~oam_dma.
REQ-010 Port dma_addr, output, 16: bus address driven during READ.
REQ-011 Port dma_rd, output, 1: bus read request.
REQ-012 Port oam_addr, output, 8: OAM write address.
REQ-013 Port oam_data_in, output, 8: OAM write data.
REQ-014 Port oam_we, output, 1: OAM write strobe.

Function
REQ-015 Trigger: a rising edge with cpu_we=1, cpu_addr==DMA_REG_ADDR and state IDLE SHALL latch page=cpu_data_out, latch the parity bit p, and enter HALT.
REQ-016 Parity: a free-running 1-bit toggle SHALL flip every clock (reset value 0); p is its value in the trigger cycle.
REQ-017 States: IDLE, HALT, ALIGN, READ, WRITE; 8-bit index idx.
REQ-018 HALT lasts 1 cycle; next state ALIGN if p=1, else READ; idx cleared to 0.
REQ-019 ALIGN lasts 1 cycle, then READ.
REQ-020 READ: dma_addr={page,idx}, dma_rd=1, 1 cycle, then WRITE.
REQ-021 WRITE: oam_we=1, oam_addr=oam_base+idx (mod 256, wraps), oam_data_in=mem_data_in (combinational), 1 cycle.
REQ-022 From WRITE: if idx==8'hFF go IDLE, else increment idx and go READ.
REQ-023 oam_dma SHALL be 1 in HALT, ALIGN, READ and WRITE, and 0 in IDLE; it is registered, rising the cycle after the trigger.
REQ-024 Total busy length SHALL be 513 cycles (p=0) or 514 cycles (p=1); exactly 256 OAM writes occur.
REQ-025 Outside READ: dma_rd=0 and dma_addr=16'h0000. Outside WRITE: oam_we=0, oam_addr=8'h00, oam_data_in=8'h00.
REQ-026 A $4014 write while not IDLE SHALL be ignored; page and p are unchanged.
REQ-027 A $4014 write in the same edge as the WRITE->IDLE transition SHALL be ignored; a trigger is accepted only from IDLE.
REQ-028 Writes to any other address SHALL have no effect.
REQ-029 oam_base SHALL be sampled live each WRITE cycle; the block does not modify it.

Reset
REQ-030 nres=0 SHALL immediately force: state IDLE, idx=0, page=0, p=0, parity toggle=0, and all outputs 0.
REQ-031 Reset mid-transfer SHALL abort with no further OAM writes; after release the block waits in IDLE for a new trigger.
REQ-032 The first clock edge after nres rises SHALL be able to accept a trigger.

Verification
REQ-033 Even start: write 8'h02 to $4014 with p=0 -> oam_dma high for 513 cycles; dma_addr steps 16'h0200..16'h02FF; OAM[i] equals RAM[16'h0200+i].
REQ-034 Odd start: same write with p=1 -> 514 busy cycles; first dma_rd occurs 3 cycles after the trigger edge.
REQ-035 Offset wrap: oam_base=8'hF0, page 8'h03 -> first write lands at oam_addr 8'hF0, byte 16 lands at 8'h00, last byte at 8'hEF.
REQ-036 Retrigger: write $4014=8'h05 during a DMA from page 8'h02 -> ignored; all 256 reads stay on page 8'h02; idle afterward.
REQ-037 Reset abort: assert nres at idx=8'h40 in WRITE -> oam_dma, oam_we and dma_rd go 0 immediately; no writes until the next trigger.
REQ-038 Non-matching: write to $4015 or $2004 -> oam_dma stays 0; no dma_rd.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite OAM DMA engine: halts the CPU and copies one 256-byte page into OAM
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
  input  logic        clk,
  input  logic        nres,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_we,
  input  logic [7:0]  mem_data_in,
  input  logic [7:0]  oam_base,
  output logic        oam_dma,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_in,
  output logic        oam_we
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic       r_p;
  logic       r_parity;
  logic       r_busy;
  logic       w_trig;

  // A launch is only honoured from IDLE; writes arriving mid-transfer or to other addresses are dropped.
  assign w_trig = cpu_we && (cpu_addr == DMA_REG_ADDR) && (r_state == S_IDLE);

  // Free-running get/put cycle parity; decides whether an extra alignment cycle is needed.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Launch capture (page and parity) and byte index; idx wraps FF->00 on the final write.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_page <= 8'h00;
      r_p    <= 1'b0;
      r_idx  <= 8'h00;
    end else begin
      if (w_trig) begin
        r_page <= cpu_data_out;
        r_p    <= r_parity;
      end
      if (r_state == S_HALT) begin
        r_idx <= 8'h00;
      end else if (r_state == S_WRITE) begin
        r_idx <= r_idx + 8'h01;
      end
    end
  end

  // Registered busy flag so the CPU stall line comes straight from a flop.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
    end
  end

  assign oam_dma = r_busy;

  // Next-state decode and per-state bus/OAM strobes; everything idles at zero.
  always_comb begin
    w_next      = r_state;
    dma_addr    = 16'h0000;
    dma_rd      = 1'b0;
    oam_addr    = 8'h00;
    oam_data_in = 8'h00;
    oam_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_next = S_HALT;
        end
      end
      S_HALT: begin
        w_next = r_p ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        w_next = S_READ;
      end
      S_READ: begin
        dma_addr = {r_page, r_idx};
        dma_rd   = 1'b1;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        oam_we      = 1'b1;
        oam_addr    = oam_base + r_idx;
        oam_data_in = mem_data_in;
        w_next      = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - directed self-checking bench for oam_dma_ctrl
module tb_oam_dma_ctrl;

  logic        clk;
  logic        nres;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_we;
  logic [7:0]  mem_data_in;
  logic [7:0]  oam_base;
  logic        oam_dma;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_in;
  logic        oam_we;

  int n_vec = 0;
  int n_err = 0;
  logic tb_par;
  logic [7:0] tb_mem;

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014)) dut (
    .clk(clk), .nres(nres), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_we(cpu_we), .mem_data_in(mem_data_in), .oam_base(oam_base),
    .oam_dma(oam_dma), .dma_addr(dma_addr), .dma_rd(dma_rd),
    .oam_addr(oam_addr), .oam_data_in(oam_data_in), .oam_we(oam_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ram(input logic [15:0] a);
    ram = (a[7:0] * 8'd3 + a[15:8]) ^ 8'hA5;
  endfunction

  // Bus responder: read data arrives the cycle after dma_rd; a non-zero filler otherwise.
  always @(posedge clk) tb_mem <= dma_rd ? ram(dma_addr) : 8'hEE;
  assign mem_data_in = tb_mem;

  // Reference parity: toggles every clock from 0 after reset.
  always @(posedge clk or negedge nres) begin
    if (!nres) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic align_parity(input logic want);
    if (tb_par !== want) tick();
  endtask

  task automatic run_dma(input logic [7:0] page, input logic [7:0] base,
                         input int retrig_cyc, input logic want_p);
    int busy;
    int reads;
    int writes;
    int first_rd;
    logic [15:0] exp_addr;
    busy = 0; reads = 0; writes = 0; first_rd = 0;
    cpu_addr = 16'h4014; cpu_data_out = page; cpu_we = 1'b1; oam_base = base;
    tick();
    cpu_we = 1'b0;
    chk("busy_rise", {15'd0, oam_dma}, 16'd1);
    for (int cyc = 1; cyc <= 600; cyc++) begin
      if (!oam_dma) break;
      busy++;
      if (dma_rd) begin
        if (first_rd == 0) first_rd = cyc;
        exp_addr = {page, 8'(reads)};
        chk("rd_addr", dma_addr, exp_addr);
        reads++;
      end else begin
        chk("rd_addr_idle", dma_addr, 16'h0000);
      end
      if (oam_we) begin
        exp_addr = {page, 8'(writes)};
        chk("oam_addr", {8'h00, oam_addr}, {8'h00, base + 8'(writes)});
        chk("oam_data", {8'h00, oam_data_in}, {8'h00, ram(exp_addr)});
        writes++;
      end else begin
        chk("oam_idle", {oam_addr, oam_data_in}, 16'h0000);
      end
      cpu_we = (cyc == retrig_cyc);
      cpu_data_out = (cyc == retrig_cyc) ? 8'h05 : page;
      tick();
      cpu_we = 1'b0;
    end
    chk("busy_len", 16'(busy), 16'(513 + int'(want_p)));
    chk("n_reads", 16'(reads), 16'd256);
    chk("n_writes", 16'(writes), 16'd256);
    chk("first_rd", 16'(first_rd), 16'(2 + int'(want_p)));
  endtask

  initial begin
    int bad;
    bit found;
    nres = 1'b0; cpu_addr = 16'h0000; cpu_data_out = 8'h00; cpu_we = 1'b0; oam_base = 8'h00;
    #3;
    chk("rst_dma", {15'd0, oam_dma}, 16'd0);
    chk("rst_rd", {15'd0, dma_rd}, 16'd0);
    chk("rst_we", {15'd0, oam_we}, 16'd0);
    chk("rst_addr", dma_addr, 16'h0000);
    chk("rst_oam", {oam_addr, oam_data_in}, 16'h0000);
    repeat (3) tick();
    nres = 1'b1;

    // Writes to neighbouring registers must not start anything.
    cpu_we = 1'b1; cpu_addr = 16'h4015; cpu_data_out = 8'h02; tick();
    cpu_addr = 16'h2004; tick();
    cpu_we = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (oam_dma !== 1'b0 || dma_rd !== 1'b0) bad++;
      tick();
    end
    chk("nonmatch", 16'(bad), 16'd0);

    align_parity(1'b0); run_dma(8'h02, 8'h00, 0, 1'b0);
    align_parity(1'b1); run_dma(8'h02, 8'h00, 0, 1'b1);
    align_parity(1'b0); run_dma(8'h03, 8'hF0, 0, 1'b0);
    align_parity(1'b1); run_dma(8'h02, 8'h10, 100, 1'b1);
    align_parity(1'b0); run_dma(8'h07, 8'h00, 513, 1'b0);
    chk("idle_after_end_retrig", {14'd0, oam_dma, dma_rd}, 16'd0);
    tick();
    chk("idle_after_end_retrig2", {14'd0, oam_dma, dma_rd}, 16'd0);

    // Reset in the middle of a transfer at idx 0x40.
    cpu_addr = 16'h4014; cpu_data_out = 8'h04; cpu_we = 1'b1; oam_base = 8'h00;
    tick();
    cpu_we = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (oam_we && oam_addr == 8'h40) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reached", {15'd0, found}, 16'd1);
    nres = 1'b0;
    #1;
    chk("abort_dma", {15'd0, oam_dma}, 16'd0);
    chk("abort_we", {15'd0, oam_we}, 16'd0);
    chk("abort_rd", {15'd0, dma_rd}, 16'd0);
    tick();
    nres = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (oam_we !== 1'b0 || dma_rd !== 1'b0 || oam_dma !== 1'b0) bad++;
      tick();
    end
    chk("abort_quiet", 16'(bad), 16'd0);

    // Trigger on the very first edge after reset release (parity is 0 there).
    nres = 1'b0;
    tick();
    nres = 1'b1;
    run_dma(8'h06, 8'h20, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
